uart_rx: RTL and testbench

UART receiver. Consumes the oversampled tick from uart_baudrate_gen, shares it with uart_tx, and deserialises the asynchronous serial input.
- Frame format is 8N1 by default: 1 start bit, DATA_BITS data bits sent LSB first, 1 stop bit, no parity.
- Each received byte is delivered through a one-entry valid/ready output buffer.
- Instantiated in top beside uart_tx. Its serial input is driven by uart_txd_in.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_sync_2ff.sv | 35 +++
 rtl/uart_rx.sv | 172 +++++++++++++++++
 tb/tb_uart_rx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared UART definitions: default frame/oversampling constants used by
//   uart_rx, uart_tx and uart_baudrate_gen, and the receiver FSM state type.
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

endpackage

// File: rtl/uart_sync_2ff.sv
// ---------------------------------------------------------------------------
// uart_sync_2ff
//   1-bit two-flop synchroniser for an asynchronous input.
//   Ports:
//     i_clk    in  : system clock, rising edge
//     i_rst_n  in  : asynchronous active-low reset
//     i_d      in  : asynchronous input
//     o_q      out : synchronised output (2 cycles latency)
//   RST_VAL sets the value both flops take in reset (idle level of i_d).
// ---------------------------------------------------------------------------
module uart_sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   UART receiver, 1 start bit, DATA_BITS data bits LSB first, 1 stop bit,
//   no parity. Samples on the oversampled tick shared with uart_tx.
//   Ports:
//     clk        in  : system clock, rising edge
//     reset_n    in  : asynchronous active-low reset
//     tick       in  : one-cycle enable, OVERSAMPLE pulses per bit period
//     rx         in  : asynchronous serial input, idles high
//     m_data     out : received byte
//     m_valid    out : m_data holds an unconsumed byte
//     m_ready    in  : consumer accepts m_data (transfer on m_valid&&m_ready)
//     busy       out : receiver FSM is not idle
//     frame_err  out : one-cycle pulse, stop bit sampled low
//     overrun    out : one-cycle pulse, completed byte dropped (buffer full)
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = UART_DATA_BITS,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned S_W = $clog2(OVERSAMPLE);
  localparam int unsigned N_W = $clog2(DATA_BITS);

  localparam logic [S_W-1:0] S_MID  = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(DATA_BITS - 1);

  logic                 w_rx_s;

  uart_rx_state_t       r_state;
  uart_rx_state_t       w_state_nxt;
  logic [S_W-1:0]       r_s_cnt;
  logic [S_W-1:0]       w_s_cnt_nxt;
  logic [N_W-1:0]       r_n_cnt;
  logic [N_W-1:0]       w_n_cnt_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 w_done;
  logic                 w_ferr;

  logic [DATA_BITS-1:0] r_m_data;
  logic                 r_m_valid;
  logic                 r_busy;
  logic                 r_frame_err;
  logic                 r_overrun;

  uart_sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_d     (rx),
    .o_q     (w_rx_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_s_cnt <= '0;
      r_n_cnt <= '0;
      r_shift <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_s_cnt <= w_s_cnt_nxt;
      r_n_cnt <= w_n_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s_cnt_nxt = r_s_cnt;
    w_n_cnt_nxt = r_n_cnt;
    w_shift_nxt = r_shift;
    w_done      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      // Start detection runs every clock, independent of tick.
      IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = START;
          w_s_cnt_nxt = '0;
        end
      end
      START: begin
        if (tick) begin
          if (r_s_cnt == S_MID) begin
            if (!w_rx_s) begin
              w_state_nxt = DATA;
              w_s_cnt_nxt = '0;
              w_n_cnt_nxt = '0;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_s_cnt_nxt = r_s_cnt + S_W'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (r_s_cnt == S_LAST) begin
            w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
            w_s_cnt_nxt = '0;
            if (r_n_cnt == N_LAST) begin
              w_state_nxt = STOP;
            end else begin
              w_n_cnt_nxt = r_n_cnt + N_W'(1);
            end
          end else begin
            w_s_cnt_nxt = r_s_cnt + S_W'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (r_s_cnt == S_LAST) begin
            // Leave at mid stop bit so a back-to-back start edge is not missed.
            w_state_nxt = IDLE;
            w_done      = w_rx_s;
            w_ferr      = !w_rx_s;
          end else begin
            w_s_cnt_nxt = r_s_cnt + S_W'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // One-entry output buffer; a drain in the completion cycle frees the slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_m_data    <= '0;
      r_m_valid   <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      r_overrun   <= w_done && r_m_valid && !m_ready;
      if (w_done && (!r_m_valid || m_ready)) begin
        r_m_data  <= r_shift;
        r_m_valid <= 1'b1;
      end else if (r_m_valid && m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign m_data    = r_m_data;
  assign m_valid   = r_m_valid;
  assign busy      = r_busy;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//   Directed bench for uart_rx: tick every 4 clks, OVERSAMPLE=16, 8N1.
//   Frames always start on a fixed tick phase, so the completion edge is the
//   608th posedge after the start bit is driven.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tick = 1'b0;
  logic       rx;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;

  int          xfers;
  int          valid_cycles;
  int          busy_cycles;
  int          ferr_cnt;
  int          ovr_cnt;
  logic [7:0]  last_xfer;
  bit          both_seen = 1'b0;

  uart_rx #(
    .DATA_BITS  (8),
    .OVERSAMPLE (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick      (tick),
    .rx        (rx),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Tick is high for the cycle ending at every 4th posedge.
  always @(negedge clk) begin
    cyc  = cyc + 1;
    tick = (cyc % 4 == 0);
  end

  // Observe outputs mid-cycle, after inputs driven at negedge+1 have settled.
  always begin
    @(negedge clk);
    #2;
    if (reset_n === 1'b1) begin
      if (m_valid)             valid_cycles++;
      if (busy)                busy_cycles++;
      if (frame_err)           ferr_cnt++;
      if (overrun)             ovr_cnt++;
      if (frame_err && overrun) both_seen = 1'b1;
      if (m_valid && m_ready) begin
        xfers++;
        last_xfer = m_data;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clr();
    xfers        = 0;
    valid_cycles = 0;
    busy_cycles  = 0;
    ferr_cnt     = 0;
    ovr_cnt      = 0;
    last_xfer    = 8'h00;
  endtask

  task automatic align();
    do clks(1); while (cyc % 4 != 1);
  endtask

  // stop_ok=0 holds the stop bit low for 40 clks (past its mid-sample).
  // rdy_pulse=1 raises m_ready only for the cycle ending at the completion edge.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit rdy_pulse);
    int b;
    align();
    for (int c = 0; c < 640; c++) begin
      b = c / 64;
      if (b == 0)      rx = 1'b0;
      else if (b < 9)  rx = d[b-1];
      else if (stop_ok) rx = 1'b1;
      else             rx = (c < 616) ? 1'b0 : 1'b1;
      if (rdy_pulse) m_ready = (c == 607);
      clks(1);
    end
    rx = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    rx      = 1'b1;
    m_ready = 1'b1;
    clr();
    clks(5);
    check_eq("rst_m_data",    32'(m_data),    32'h00);
    check_eq("rst_m_valid",   32'(m_valid),   32'h0);
    check_eq("rst_busy",      32'(busy),      32'h0);
    check_eq("rst_frame_err", 32'(frame_err), 32'h0);
    check_eq("rst_overrun",   32'(overrun),   32'h0);
    reset_n = 1'b1;
    clks(5);

    // Clean frame 0xA5, consumer always ready.
    clr();
    send_frame(8'hA5, 1'b1, 1'b0);
    clks(8);
    check_eq("a5_xfers",   32'(xfers),        32'd1);
    check_eq("a5_data",    32'(last_xfer),    32'hA5);
    check_eq("a5_vcycles", 32'(valid_cycles), 32'd1);
    check_eq("a5_ferr",    32'(ferr_cnt),     32'd0);
    check_eq("a5_busy",    32'(busy),         32'h0);
    check_eq("a5_busy_len", 32'(busy_cycles >= 600 && busy_cycles <= 610), 32'h1);

    // Short low glitch rejected at mid start bit.
    clr();
    align();
    rx = 1'b0;
    clks(12);
    rx = 1'b1;
    clks(60);
    check_eq("gl_xfers",   32'(xfers),        32'd0);
    check_eq("gl_vcycles", 32'(valid_cycles), 32'd0);
    check_eq("gl_ferr",    32'(ferr_cnt),     32'd0);
    check_eq("gl_busy",    32'(busy),         32'h0);
    check_eq("gl_busy_len", 32'(busy_cycles >= 20 && busy_cycles <= 40), 32'h1);

    // Bad stop bit, then a good frame.
    clr();
    send_frame(8'h3C, 1'b0, 1'b0);
    clks(100);
    check_eq("fe_ferr",    32'(ferr_cnt),     32'd1);
    check_eq("fe_vcycles", 32'(valid_cycles), 32'd0);
    check_eq("fe_xfers",   32'(xfers),        32'd0);
    check_eq("fe_busy",    32'(busy),         32'h0);
    clr();
    send_frame(8'h55, 1'b1, 1'b0);
    clks(8);
    check_eq("55_xfers", 32'(xfers),     32'd1);
    check_eq("55_data",  32'(last_xfer), 32'h55);
    check_eq("55_ferr",  32'(ferr_cnt),  32'd0);

    // Overrun: two frames with the consumer stalled.
    clr();
    m_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    clks(8);
    check_eq("ov_valid",  32'(m_valid), 32'h1);
    check_eq("ov_data",   32'(m_data),  32'h11);
    check_eq("ov_count",  32'(ovr_cnt), 32'd1);
    check_eq("ov_xfers",  32'(xfers),   32'd0);
    m_ready = 1'b1;
    clks(3);
    check_eq("ov_drain_xfers", 32'(xfers),     32'd1);
    check_eq("ov_drain_data",  32'(last_xfer), 32'h11);
    check_eq("ov_drain_valid", 32'(m_valid),   32'h0);

    // Drain in the exact completion cycle of the next byte.
    clr();
    m_ready = 1'b0;
    send_frame(8'h7E, 1'b1, 1'b0);
    send_frame(8'h80, 1'b1, 1'b1);
    clks(8);
    check_eq("sc_valid", 32'(m_valid),   32'h1);
    check_eq("sc_data",  32'(m_data),    32'h80);
    check_eq("sc_ovr",   32'(ovr_cnt),   32'd0);
    check_eq("sc_xfers", 32'(xfers),     32'd1);
    check_eq("sc_first", 32'(last_xfer), 32'h7E);
    m_ready = 1'b1;
    clks(3);
    check_eq("sc_drain_xfers", 32'(xfers),     32'd2);
    check_eq("sc_drain_data",  32'(last_xfer), 32'h80);
    check_eq("sc_drain_valid", 32'(m_valid),   32'h0);

    // Reset mid DATA of 0xFF with a byte pending, then recover.
    clr();
    m_ready = 1'b0;
    send_frame(8'h5A, 1'b1, 1'b0);
    clks(8);
    check_eq("rm_pending", 32'(m_valid), 32'h1);
    align();
    rx = 1'b0;
    clks(64);
    rx = 1'b1;
    clks(100);
    check_eq("rm_busy_pre", 32'(busy), 32'h1);
    reset_n = 1'b0;
    #1;
    check_eq("rm_m_valid",   32'(m_valid),   32'h0);
    check_eq("rm_m_data",    32'(m_data),    32'h00);
    check_eq("rm_busy",      32'(busy),      32'h0);
    check_eq("rm_frame_err", 32'(frame_err), 32'h0);
    check_eq("rm_overrun",   32'(overrun),   32'h0);
    clks(5);
    reset_n = 1'b1;
    clks(700);
    check_eq("rm_no_ferr",  32'(ferr_cnt), 32'd0);
    check_eq("rm_no_ovr",   32'(ovr_cnt),  32'd0);
    check_eq("rm_no_valid", 32'(m_valid),  32'h0);
    clr();
    m_ready = 1'b1;
    send_frame(8'h0F, 1'b1, 1'b0);
    clks(8);
    check_eq("0f_xfers", 32'(xfers),     32'd1);
    check_eq("0f_data",  32'(last_xfer), 32'h0F);

    check_eq("ferr_ovr_exclusive", 32'(both_seen), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
